// File: rtl/RV32i_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the responder FSM state encoding and the word/lane geometry.
// No ports; imported by dmem_responder and dmem_bram.
package RV32i_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NUM_LANES = XLEN / 8;
  // Wait-cycle counter wide enough for latencies 0..15.
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } dmem_rsp_state_t;

endpackage

// File: rtl/dmem_bram.sv
// Byte-lane word storage with per-lane write enables and a synchronous read register.
// Latency: write and read both take effect at the clock edge where they are enabled.
// No backpressure; the caller strobes we_i/re_i for exactly one edge per access.
// Ports:
//   clk_i, rst_i   clock; async active-high reset of the read register only (storage keeps contents)
//   we_i           per-lane write enables, lane n = wdata_i[8n+7:8n]
//   addr_i         word index shared by read and write
//   wdata_i        write data
//   re_i           load the full stored word into rdata_o
//   rclr_i         load zero into rdata_o (used for rejected reads)
//   rdata_o        registered read data, holds between loads
module dmem_bram
  import RV32i_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_LANES-1:0] we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [XLEN-1:0]      wdata_i,
  input  logic                 re_i,
  input  logic                 rclr_i,
  output logic [XLEN-1:0]      rdata_o
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    // Storage is deliberately outside the reset domain so contents survive rst_i.
    always_ff @(posedge clk_i) begin
      if (we_i[l]) begin
        lane_mem[addr_i] <= wdata_i[8*l +: 8];
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rd_q <= '0;
      end else if (rclr_i) begin
        rd_q <= '0;
      end else if (re_i) begin
        rd_q <= lane_mem[addr_i];
      end
    end

    assign rdata_o[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for a stalling core: accepts a held we/re request, waits LATENCY cycles, then accesses storage.
// Latency: request first seen in IDLE cycle k completes with a one-cycle valid pulse in cycle k+1+LATENCY.
// Backpressure: the core holds the request until dmem_valid_o; new requests are sampled only in IDLE.
// Ports:
//   clk_i, rst_i      clock; async active-high reset (FSM, counter, outputs; storage untouched)
//   dmem_add_i        byte address, word index = (addr-BASE_ADDR)[31:2]
//   dmem_di_i         write data
//   dmem_we_i/re_i    write / read request, held until the response
//   dmem_ble_i        byte-lane enables for writes
//   dmem_do_o         registered read data, changes only on a completed read
//   dmem_valid_o      registered one-cycle completion pulse
//   err_o             registered error pulse coincident with dmem_valid_o
module dmem_responder
  import RV32i_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [XLEN-1:0]      dmem_add_i,
  input  logic [XLEN-1:0]      dmem_di_i,
  input  logic                 dmem_we_i,
  input  logic                 dmem_re_i,
  input  logic [NUM_LANES-1:0] dmem_ble_i,
  output logic [XLEN-1:0]      dmem_do_o,
  output logic                 dmem_valid_o,
  output logic                 err_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  dmem_rsp_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             access;

  // Address decode. The borrow out of the subtraction flags addresses below BASE_ADDR.
  logic             below_base;
  logic [31:0]      offset;
  logic [29:0]      word_idx;
  logic             out_of_range;
  logic             unused_lsb;

  assign {below_base, offset} = {1'b0, dmem_add_i} - {1'b0, BASE_ADDR};
  assign word_idx     = offset[31:2];
  assign unused_lsb   = ^offset[1:0];
  assign out_of_range = below_base || (word_idx >= 30'(DEPTH_WORDS));

  logic req;
  logic conflict;
  assign req      = dmem_we_i | dmem_re_i;
  assign conflict = dmem_we_i & dmem_re_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            access  = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          // Core withdrew the request: abandon silently.
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        // The request is still visible here; ignoring it prevents a double accept.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (access) begin
      valid_d = 1'b1;
      err_d   = out_of_range | conflict;
    end
  end

  // Storage strobes: only a clean single-direction in-range access touches memory;
  // an out-of-range read clears the read register, a conflicting request leaves it alone.
  logic                 access_ok;
  logic [NUM_LANES-1:0] mem_we;
  logic                 mem_re;
  logic                 mem_rclr;

  assign access_ok = access & ~conflict & ~out_of_range;
  assign mem_we    = {NUM_LANES{access_ok & dmem_we_i}} & dmem_ble_i;
  assign mem_re    = access_ok & dmem_re_i;
  assign mem_rclr  = access & ~conflict & out_of_range & dmem_re_i;

  dmem_bram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (mem_we),
    .addr_i (word_idx[AW-1:0]),
    .wdata_i(dmem_di_i),
    .re_i   (mem_re),
    .rclr_i (mem_rclr),
    .rdata_o(dmem_do_o)
  );

  assign dmem_valid_o = valid_q;
  assign err_o        = err_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored; the SHALL be a power of two.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 Parameter LATENCY, default 2, wait cycles inserted before each response (0..15).
REQ-004 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 dmem_add_i  input  32  byte address from the core.
REQ-007 dmem_di_i  input  32  write data.
REQ-008 dmem_we_i  input  1  write request, held until the response.
REQ-009 dmem_re_i  input  1  read request, held until the response.
REQ-010 dmem_ble_i  input  4  byte-lane enables; bit n selects byte [8n+7:8n].
REQ-011 dmem_do_o  output  32  read data; it SHALL be registered.
REQ-012 dmem_valid_o  output  1  one-cycle completion pulse; it SHALL be registered.
REQ-013 err_o  output  1  one-cycle error pulse, coincident with dmem_valid_o.

Function
REQ-014 A request SHALL be any cycle with dmem_we_i or dmem_re_i high. The core holds the request stable and stalls while dmem_valid_o is low.
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 IDLE with a request and LATENCY=0: the access SHALL be performed at that edge and the FSM SHALL go to RESP.
REQ-017 IDLE with a request and LATENCY>0: the FSM SHALL go to WAIT with the counter loaded to LATENCY-1.
REQ-018 WAIT with counter=0: the access SHALL be performed at that edge and the FSM SHALL go to RESP. With counter>0, the counter SHALL decrement.
REQ-019 RESP SHALL drive dmem_valid_o=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-020 Latency: a request first present in cycle k SHALL receive dmem_valid_o high in cycle k+1+LATENCY.
REQ-021 The held request that is still visible during RESP SHALL NOT be accepted again. A new request is sampled only from IDLE, so back-to-back requests are separated by one RESP cycle.
REQ-022 The word index SHALL be (dmem_add_i-BASE_ADDR)[31:2]. dmem_add_i[1:0] SHALL be ignored.
REQ-023 Write: only the lanes with dmem_ble_i bit set SHALL be updated. ble=4'b0000 SHALL still complete with valid and leave memory unchanged.
REQ-024 Read: dmem_do_o SHALL load the full stored word at the access edge, regardless of ble. dmem_do_o SHALL hold its value otherwise, including across writes.
REQ-025 Read-after-write to the same word on consecutive requests SHALL return the newly written data.
REQ-026 Out-of-range address (below BASE_ADDR, or index >= DEPTH_WORDS): the block SHALL respond normally with err_o=1. A read SHALL load 0 into dmem_do_o; a write SHALL be dropped.
REQ-027 dmem_we_i and dmem_re_i both high: the block SHALL respond with err_o=1, perform no access, and leave dmem_do_o unchanged.
REQ-028 Request deasserted while in WAIT: the FSM SHALL abort to IDLE with no access and no valid pulse.

Reset
REQ-029 rst_i high SHALL immediately force state=IDLE, counter=0, dmem_valid_o=0, err_o=0 and dmem_do_o=0.
REQ-030 Reset during WAIT or RESP SHALL discard the pending access; no valid or err pulse SHALL follow.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-032 The state enum dmem_rsp_state_t {ST_IDLE, ST_WAIT, ST_RESP} SHALL live in RV32i_pkg.
REQ-033 The storage SHALL be a sub-module dmem_bram: 4 byte lanes, per-lane write enable, synchronous read, DEPTH_WORDS parameter.
REQ-034 The FSM, counter, address decode and error logic SHALL stay in dmem_responder.

Verification
REQ-035 LATENCY=2: write 0xDEADBEEF, ble=4'hF, to 0x10 in cycle 0 -> valid in cycle 3. A read of 0x10 issued in cycle 4 -> valid in cycle 7 with dmem_do_o=0xDEADBEEF.
REQ-036 Word 0x10=0xDEADBEEF; write 0x00005500 with ble=4'b0010 -> a subsequent read returns 0xDEAD55EF.
REQ-037 LATENCY=0: four back-to-back reads, each held until valid -> valid every second cycle, no duplicate accepts, correct data each time.
REQ-038 Read at BASE_ADDR+4*DEPTH_WORDS -> valid with err_o=1 and dmem_do_o=0. A write to the same address -> err_o=1 and memory unchanged.
REQ-039 Assert rst_i in WAIT, then release and issue a read of 0x10 -> no stale valid pulse; the read completes after LATENCY+1 cycles with the pre-reset data.
REQ-040 we=re=1 at 0x20 -> valid with err_o=1; dmem_do_o and word 0x20 unchanged.
